// File: rtl/ct_pkg.sv
// Shared definitions for the field-conversion slice: state encodings and width helpers.
package ct_pkg;

    localparam logic [1:0] CT_SLICE_EMPTY = 2'b00;
    localparam logic [1:0] CT_SLICE_ONE   = 2'b10;
    localparam logic [1:0] CT_SLICE_FULL  = 2'b11;

    // Zero-width buses are not expressible, so a zero width is carried as one unused bit.
    function automatic int ct_pad_width(input int w);
        return (w > 32'sd0) ? w : 32'sd1;
    endfunction

endpackage

// File: rtl/ct_slice_reg.sv
// Enable-loaded payload register with an optional synchronous clear.
module ct_slice_reg #(
    parameter int W       = 1,
    parameter bit HAS_CLR = 1'b0
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] val_d;
    logic [W-1:0] val_q;

    // Next value: load on enable, otherwise hold.
    always_comb begin
        val_d = val_q;
        if (en) begin
            val_d = d;
        end else begin
            val_d = val_q;
        end
    end

    // Storage; the clear is only honoured when the instance asks for it.
    always_ff @(posedge clk) begin
        if (HAS_CLR && clr) begin
            val_q <= '0;
        end else begin
            val_q <= val_d;
        end
    end

    assign q = val_q;

endmodule

// File: rtl/ct_field_reg_slice.sv
// Two-entry skid slice for the data+field stream; every output comes straight from a flop.
module ct_field_reg_slice
    import ct_pkg::*;
#(
    parameter int WD         = 0,
    parameter int WF         = 1,
    parameter bit RESET_DATA = 1'b0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [ct_pad_width(WD)-1:0] i_data,
    input  logic [WF-1:0]              i_field,
    input  logic                       i_valid,
    output logic                       o_ready,
    output logic [ct_pad_width(WD)-1:0] o_data,
    output logic [WF-1:0]              o_field,
    output logic                       o_valid,
    input  logic                       i_ready
);

    localparam int DW = ct_pad_width(WD);

    logic       main_v_d, main_v_q;
    logic       skid_v_d, skid_v_q;
    logic       ready_d,  ready_q;
    logic       in_xfer_s, out_xfer_s;
    logic       main_ld_s, main_from_skid_s, skid_ld_s;
    logic [1:0] state_s;

    logic [WF-1:0] main_field_in_s;
    logic [WF-1:0] main_field_q;
    logic [WF-1:0] skid_field_q;

    assign in_xfer_s  = i_valid & ready_q;
    assign out_xfer_s = main_v_q & i_ready;
    assign state_s    = {main_v_q, skid_v_q};

    // Occupancy control: decides which register loads and the next valid bits.
    always_comb begin
        main_v_d         = main_v_q;
        skid_v_d         = skid_v_q;
        main_ld_s        = 1'b0;
        main_from_skid_s = 1'b0;
        skid_ld_s        = 1'b0;
        case (state_s)
            CT_SLICE_EMPTY: begin
                if (in_xfer_s) begin
                    main_ld_s = 1'b1;
                    main_v_d  = 1'b1;
                end else begin
                    main_v_d  = 1'b0;
                end
            end
            CT_SLICE_ONE: begin
                if (in_xfer_s && out_xfer_s) begin
                    main_ld_s = 1'b1;
                end else if (in_xfer_s) begin
                    skid_ld_s = 1'b1;
                    skid_v_d  = 1'b1;
                end else if (out_xfer_s) begin
                    main_v_d  = 1'b0;
                end else begin
                    main_v_d  = 1'b1;
                end
            end
            CT_SLICE_FULL: begin
                // Upstream is stalled here, so only a drain can move state.
                if (out_xfer_s) begin
                    main_ld_s        = 1'b1;
                    main_from_skid_s = 1'b1;
                    skid_v_d         = 1'b0;
                end else begin
                    skid_v_d         = 1'b1;
                end
            end
            default: begin
                main_v_d = 1'b0;
                skid_v_d = 1'b0;
            end
        endcase
        ready_d = ~skid_v_d;
    end

    // Control flops; ready stays low for as long as reset is held.
    always_ff @(posedge clk) begin
        if (reset) begin
            main_v_q <= 1'b0;
            skid_v_q <= 1'b0;
            ready_q  <= 1'b0;
        end else begin
            main_v_q <= main_v_d;
            skid_v_q <= skid_v_d;
            ready_q  <= ready_d;
        end
    end

    // Main field source: the skid entry when draining, otherwise the live input.
    always_comb begin
        main_field_in_s = i_field;
        if (main_from_skid_s) begin
            main_field_in_s = skid_field_q;
        end else begin
            main_field_in_s = i_field;
        end
    end

    ct_slice_reg #(.W(WF), .HAS_CLR(RESET_DATA)) u_main_field (
        .clk (clk),
        .clr (reset),
        .en  (main_ld_s),
        .d   (main_field_in_s),
        .q   (main_field_q)
    );

    ct_slice_reg #(.W(WF), .HAS_CLR(RESET_DATA)) u_skid_field (
        .clk (clk),
        .clr (reset),
        .en  (skid_ld_s),
        .d   (i_field),
        .q   (skid_field_q)
    );

    if (WD > 0) begin : g_data
        logic [DW-1:0] main_data_in_s;
        logic [DW-1:0] main_data_q;
        logic [DW-1:0] skid_data_q;

        // Main data source, steered exactly like the field.
        always_comb begin
            main_data_in_s = i_data;
            if (main_from_skid_s) begin
                main_data_in_s = skid_data_q;
            end else begin
                main_data_in_s = i_data;
            end
        end

        ct_slice_reg #(.W(DW), .HAS_CLR(RESET_DATA)) u_main_data (
            .clk (clk),
            .clr (reset),
            .en  (main_ld_s),
            .d   (main_data_in_s),
            .q   (main_data_q)
        );

        ct_slice_reg #(.W(DW), .HAS_CLR(RESET_DATA)) u_skid_data (
            .clk (clk),
            .clr (reset),
            .en  (skid_ld_s),
            .d   (i_data),
            .q   (skid_data_q)
        );

        assign o_data = main_data_q;
    end else begin : g_no_data
        logic unused_data_s;
        assign unused_data_s = ^i_data;
        assign o_data        = '0;
    end

    assign o_field = main_field_q;
    assign o_valid = main_v_q;
    assign o_ready = ready_q;

endmodule

// File: doc/ct_field_reg_slice.md
Name: ct_field_reg_slice

Overview:
Registered valid/ready pipeline slice for the data+field stream produced by the field conversion stage. It sits directly downstream of that stage and upstream of the interconnect.
It breaks the combinational valid, data, field and ready paths that the conversion stage passes straight through. It sustains full throughput (one beat per cycle) using a two-entry skid buffer.
Field and data are carried separately and are never modified.

Parameters:
WD, 0, width of passthrough data (excludes field); WD=0 is legal (no data register generated)
WF, 1, width of field; must be >= 1
RESET_DATA, 0, when 1, data/field registers are also cleared by reset; when 0, only control state is reset

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
i_data  input  WD  upstream passthrough data (excludes field)
i_field  input  WF  upstream field (already converted)
i_valid  input  1  upstream beat valid
o_ready  output  1  ready to upstream; driven from a register only
o_data  output  WD  downstream data, registered
o_field  output  WF  downstream field, registered
o_valid  output  1  downstream beat valid, registered
i_ready  input  1  downstream ready

Behaviour:
- One clock; reset is synchronous and active-high, sampled on the rising edge of clk.
- Transfer definitions: in_xfer = i_valid & o_ready; out_xfer = o_valid & i_ready.
- Storage: main register {data, field, main_v}; skid register {data, field, skid_v}. o_data/o_field/o_valid come from main; o_ready = ~skid_v, held in its own flop.
- Reset values: o_valid=0; skid_v=0; o_ready=0 while reset is asserted; o_ready=1 from the first edge after reset deasserts. o_data/o_field = 0 after reset if RESET_DATA=1, otherwise don't-care.
- States, encoded by {main_v, skid_v}: EMPTY=00, ONE=10, FULL=11 (01 is unreachable).
- EMPTY: in_xfer -> capture input into main, go to ONE. No in_xfer -> stay in EMPTY.
- ONE, in_xfer & out_xfer -> capture input into main, stay in ONE (streaming).
- ONE, in_xfer & ~out_xfer -> capture input into skid, go to FULL; o_ready falls on the same edge.
- ONE, ~in_xfer & out_xfer -> go to EMPTY.
- ONE, neither -> hold.
- FULL: o_ready=0, so in_xfer is impossible. out_xfer -> main<=skid, clear skid_v, go to ONE; o_ready rises on the same edge. No out_xfer -> hold.
- Latency: 1 cycle from in_xfer to o_valid when EMPTY. Throughput: 1 beat/cycle with i_ready held high.
- Ordering: beats leave in arrival order; no beat is dropped or duplicated.
- Data/field stability: while o_valid=1 & i_ready=0, o_data/o_field/o_valid must not change.
- No combinational path from any input to any output.
- Unqualified inputs: i_data/i_field are ignored when i_valid=0, and i_valid is ignored when o_ready=0.
- Reset mid-operation: any stored beats are discarded; o_valid=0 on the edge where reset is sampled high.
- Width rules: WD=0 generates no data flops, and o_data is then unused.

Decomposition:
- Shared package (ct_pkg): state encoding constants CT_SLICE_EMPTY/ONE/FULL as 2-bit localparams. Reuse the package's field-width checks if present.
- Sub-module: ct_slice_reg, a plain enable-loaded register with optional synchronous clear, instantiated for the main and skid payloads. Control logic stays in the top module.

Test Plan:
- Reset/idle: hold reset 3 cycles, then release -> o_valid=0 throughout; o_ready=0 during reset; o_ready=1 exactly one edge after release.
- Streaming: i_ready=1; send 8 beats back-to-back with data 0x10..0x17 and field 0..7 -> identical sequence on o_data/o_field, each 1 cycle later; o_ready stays 1 throughout.
- Single stall: send beats A,B,C continuously; drop i_ready for 1 cycle while A is on the output -> B goes into skid and o_ready=0 for one cycle. Output is A(held), A, B, C with no loss; upstream holds C until o_ready=1.
- Long backpressure: i_ready=0 for 10 cycles while pushing -> exactly 2 beats accepted; o_ready=0 from the 3rd cycle on. After i_ready=1, both beats drain in order, then o_ready=1.
- Random valid/ready: 10k cycles of random i_valid/i_ready (50%), WD=32, WF=4 -> scoreboard matches in order; o_data/o_field stable whenever o_valid & ~i_ready.
- Reset mid-operation: reach FULL, assert reset for 1 cycle -> o_valid=0 next edge; stored beats never appear on the output. A new beat after reset passes with 1-cycle latency.
